// File: rtl/itch_add_order_parser_if.sv
// Beat stream from the ITCH message-type decoder into the add-order parser.
// in_valid qualifies in_data and start each cycle; there is no back-pressure (no ready), so every valid beat is consumed.
interface itch_add_order_parser_if;
  logic        start;
  logic        in_valid;
  logic [63:0] in_data;

  modport master (output start, output in_valid, output in_data);
  modport slave  (input start, input in_valid, input in_data);
endinterface

// File: rtl/itch_add_order_parser.sv
// Collects the five 64-bit beats of an ITCH Add Order (no MPID) message and
// presents every field as registered outputs with a one-cycle out_valid strobe.
module itch_add_order_parser #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [15:0] EXP_LEN = 16'd36
) (
  input  logic                    clk,
  input  logic                    rst,
  itch_add_order_parser_if.slave  i_msg,
  output logic                    o_busy,
  output logic                    o_out_valid,
  output logic [15:0]             o_msg_length,
  output logic [15:0]             o_stock_locate,
  output logic [15:0]             o_tracking_number,
  output logic [47:0]             o_timestamp,
  output logic [63:0]             o_order_ref,
  output logic                    o_buy_sell,
  output logic [31:0]             o_shares,
  output logic [63:0]             o_stock,
  output logic [31:0]             o_price,
  output logic                    o_length_err,
  output logic                    o_side_err,
  output logic                    o_abort,
  output logic                    o_dbg_state
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_beat_cnt;
  logic [2:0]  w_beat_cnt_nxt;
  logic [7:0]  r_tmo;
  logic [7:0]  w_tmo_nxt;
  logic [7:0]  w_tmo_inc;
  logic        w_store;
  logic [1:0]  w_store_idx;
  logic        w_complete;
  logic        w_abort;

  logic [63:0] r_buf [4];
  logic [7:0]  w_bytes [40];

  logic        r_out_valid;
  logic        r_abort;
  logic [15:0] r_msg_length;
  logic [15:0] r_stock_locate;
  logic [15:0] r_tracking_number;
  logic [47:0] r_timestamp;
  logic [63:0] r_order_ref;
  logic        r_buy_sell;
  logic [31:0] r_shares;
  logic [63:0] r_stock;
  logic [31:0] r_price;
  logic        r_length_err;
  logic        r_side_err;

  logic [15:0] w_msg_length;
  logic [7:0]  w_side;

  assign w_tmo_inc = r_tmo + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_tmo_nxt      = r_tmo;
    w_store        = 1'b0;
    w_store_idx    = 2'd0;
    w_complete     = 1'b0;
    w_abort        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_msg.start && i_msg.in_valid) begin
          w_next_state   = ST_COLLECT;
          w_store        = 1'b1;
          w_beat_cnt_nxt = 3'd1;
          w_tmo_nxt      = 8'd0;
        end
      end
      ST_COLLECT: begin
        if (i_msg.start && i_msg.in_valid) begin
          // A fresh start overrides the partial message and becomes its beat 0.
          w_abort        = 1'b1;
          w_store        = 1'b1;
          w_beat_cnt_nxt = 3'd1;
          w_tmo_nxt      = 8'd0;
        end else if (i_msg.in_valid) begin
          w_tmo_nxt = 8'd0;
          if (r_beat_cnt == 3'd4) begin
            w_complete     = 1'b1;
            w_next_state   = ST_IDLE;
            w_beat_cnt_nxt = 3'd0;
          end else begin
            w_store        = 1'b1;
            w_store_idx    = r_beat_cnt[1:0];
            w_beat_cnt_nxt = r_beat_cnt + 3'd1;
          end
        end else if (w_tmo_inc == 8'(TIMEOUT)) begin
          w_abort        = 1'b1;
          w_next_state   = ST_IDLE;
          w_beat_cnt_nxt = 3'd0;
          w_tmo_nxt      = 8'd0;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Stream bytes 0..31 come from the buffer; beat 4 (bytes 32..39) is taken live.
  for (genvar k = 0; k < 32; k++) begin : g_buf_bytes
    assign w_bytes[k] = r_buf[k / 8][(k % 8) * 8 +: 8];
  end
  for (genvar k = 0; k < 8; k++) begin : g_live_bytes
    assign w_bytes[32 + k] = i_msg.in_data[k * 8 +: 8];
  end

  assign w_msg_length = {w_bytes[0], w_bytes[1]};
  assign w_side       = w_bytes[21];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt        <= 3'd0;
      r_tmo             <= 8'd0;
      for (int i = 0; i < 4; i++) r_buf[i] <= 64'd0;
      r_out_valid       <= 1'b0;
      r_abort           <= 1'b0;
      r_msg_length      <= 16'd0;
      r_stock_locate    <= 16'd0;
      r_tracking_number <= 16'd0;
      r_timestamp       <= 48'd0;
      r_order_ref       <= 64'd0;
      r_buy_sell        <= 1'b0;
      r_shares          <= 32'd0;
      r_stock           <= 64'd0;
      r_price           <= 32'd0;
      r_length_err      <= 1'b0;
      r_side_err        <= 1'b0;
    end else begin
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_out_valid <= w_complete;
      r_abort     <= w_abort;
      if (w_store) r_buf[w_store_idx] <= i_msg.in_data;
      if (w_complete) begin
        r_msg_length      <= w_msg_length;
        r_stock_locate    <= {w_bytes[3], w_bytes[4]};
        r_tracking_number <= {w_bytes[5], w_bytes[6]};
        r_timestamp       <= {w_bytes[7], w_bytes[8], w_bytes[9],
                              w_bytes[10], w_bytes[11], w_bytes[12]};
        r_order_ref       <= {w_bytes[13], w_bytes[14], w_bytes[15], w_bytes[16],
                              w_bytes[17], w_bytes[18], w_bytes[19], w_bytes[20]};
        r_buy_sell        <= (w_side == 8'h42);
        r_shares          <= {w_bytes[22], w_bytes[23], w_bytes[24], w_bytes[25]};
        r_stock           <= {w_bytes[26], w_bytes[27], w_bytes[28], w_bytes[29],
                              w_bytes[30], w_bytes[31], w_bytes[32], w_bytes[33]};
        r_price           <= {w_bytes[34], w_bytes[35], w_bytes[36], w_bytes[37]};
        r_length_err      <= (w_msg_length != EXP_LEN);
        r_side_err        <= (w_side != 8'h42) && (w_side != 8'h53);
      end
    end
  end

  assign o_busy            = (r_state == ST_COLLECT);
  assign o_dbg_state       = r_state;
  assign o_out_valid       = r_out_valid;
  assign o_abort           = r_abort;
  assign o_msg_length      = r_msg_length;
  assign o_stock_locate    = r_stock_locate;
  assign o_tracking_number = r_tracking_number;
  assign o_timestamp       = r_timestamp;
  assign o_order_ref       = r_order_ref;
  assign o_buy_sell        = r_buy_sell;
  assign o_shares          = r_shares;
  assign o_stock           = r_stock;
  assign o_price           = r_price;
  assign o_length_err      = r_length_err;
  assign o_side_err        = r_side_err;

endmodule

// File: tb/tb_itch_add_order_parser.sv
// Bench for itch_add_order_parser: messages are built from field values as a
// big-endian byte string, sliced into beats, and expected outputs come from the fields.
module tb_itch_add_order_parser;

  localparam int REC_W = 291;

  typedef struct {
    logic [15:0] len;
    logic [15:0] loc;
    logic [15:0] trk;
    logic [47:0] ts;
    logic [63:0] oref;
    logic [7:0]  side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
  } msg_t;

  logic clk;
  logic rst;

  logic        busy, out_valid, buy_sell, length_err, side_err, abort_o, dbg_state;
  logic [15:0] msg_length, stock_locate, tracking_number;
  logic [47:0] timestamp;
  logic [63:0] order_ref, stock;
  logic [31:0] shares, price;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ov_cnt = 0;
  int ab_cnt = 0;
  logic [REC_W-1:0] last_exp;

  itch_add_order_parser_if bus ();

  itch_add_order_parser #(.TIMEOUT(16), .EXP_LEN(16'd36)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_msg             (bus),
    .o_busy            (busy),
    .o_out_valid       (out_valid),
    .o_msg_length      (msg_length),
    .o_stock_locate    (stock_locate),
    .o_tracking_number (tracking_number),
    .o_timestamp       (timestamp),
    .o_order_ref       (order_ref),
    .o_buy_sell        (buy_sell),
    .o_shares          (shares),
    .o_stock           (stock),
    .o_price           (price),
    .o_length_err      (length_err),
    .o_side_err        (side_err),
    .o_abort           (abort_o),
    .o_dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) ov_cnt++;
    if (abort_o)   ab_cnt++;
  end

  // reference model
  function automatic logic [319:0] encode(msg_t m);
    logic [15:0] pad;
    pad = 16'($urandom);
    return {m.len, 8'h41, m.loc, m.trk, m.ts, m.oref, m.side, m.shares, m.stock, m.price, pad};
  endfunction

  function automatic logic [63:0] beat_of(logic [319:0] s, int n);
    logic [63:0] b;
    for (int j = 0; j < 8; j++) b[8*j +: 8] = s[319 - 8*(8*n + j) -: 8];
    return b;
  endfunction

  function automatic logic [REC_W-1:0] exp_rec(msg_t m);
    return {m.len, m.loc, m.trk, m.ts, m.oref, (m.side == 8'h42), m.shares, m.stock, m.price,
            (m.len != 16'd36), !((m.side == 8'h42) || (m.side == 8'h53))};
  endfunction

  function automatic logic [REC_W-1:0] obs_rec();
    return {msg_length, stock_locate, tracking_number, timestamp, order_ref, buy_sell,
            shares, stock, price, length_err, side_err};
  endfunction

  function automatic msg_t rand_msg();
    msg_t m;
    int   pick;
    m.len    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd36;
    m.loc    = 16'($urandom);
    m.trk    = 16'($urandom);
    m.ts     = {16'($urandom), 32'($urandom)};
    m.oref   = {32'($urandom), 32'($urandom)};
    pick     = $urandom_range(0, 2);
    m.side   = (pick == 0) ? 8'h42 : (pick == 1) ? 8'h53 : 8'($urandom);
    m.shares = 32'($urandom);
    m.stock  = {32'($urandom), 32'($urandom)};
    m.price  = 32'($urandom);
    return m;
  endfunction

  function automatic msg_t nominal_msg();
    msg_t m;
    m.len    = 16'h0024;
    m.loc    = 16'h0001;
    m.trk    = 16'h0000;
    m.ts     = 48'h00000BEBC200;
    m.oref   = 64'h0000000000000457;
    m.side   = 8'h42;
    m.shares = 32'h00000064;
    m.stock  = 64'h4141504C20202020;
    m.price  = 32'h001E8480;
    return m;
  endfunction

  // driver tasks
  task automatic drive(input logic s, input logic v, input logic [63:0] d);
    bus.start    = s;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, {32'($urandom), 32'($urandom)});
  endtask

  task automatic send(input msg_t m, input int gap);
    logic [319:0] s;
    s = encode(m);
    for (int n = 0; n < 5; n++) begin
      drive(n == 0, 1'b1, beat_of(s, n));
      if (n < 4) idle(gap);
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({obs_rec(), busy, out_valid, abort_o, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h busy=%b ov=%b abort=%b st=%b, want all zero",
               obs_rec(), busy, out_valid, abort_o, dbg_state);
    end
  endtask

  task automatic test_nominal();
    msg_t m;
    logic [319:0] s;
    m = nominal_msg();
    s = encode(m);
    for (int n = 0; n < 4; n++) begin
      drive(n == 0, 1'b1, beat_of(s, n));
      checks++;
      if ({busy, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL nominal_beat%0d: busy=%b ov=%b, want busy=1 ov=0", n, busy, out_valid);
      end
    end
    drive(1'b0, 1'b1, beat_of(s, 4));
    last_exp = exp_rec(m);
    checks++;
    if (out_valid !== 1'b1 || obs_rec() !== last_exp) begin
      errors++;
      $display("FAIL nominal_done: ov=%b rec=%h, want ov=1 rec=%h", out_valid, obs_rec(), last_exp);
    end
    idle(1);
    checks++;
    if ({busy, out_valid, abort_o} !== 3'b000) begin
      errors++;
      $display("FAIL nominal_after: busy=%b ov=%b abort=%b, want 000", busy, out_valid, abort_o);
    end
  endtask

  task automatic test_gapped();
    msg_t m;
    int ab0, ov0;
    ab0 = ab_cnt; ov0 = ov_cnt;
    m = nominal_msg();
    send(m, 3);
    last_exp = exp_rec(m);
    checks++;
    if (out_valid !== 1'b1 || obs_rec() !== last_exp) begin
      errors++;
      $display("FAIL gapped_done: ov=%b rec=%h, want ov=1 rec=%h", out_valid, obs_rec(), last_exp);
    end
    idle(2);
    checks++;
    if (ab_cnt - ab0 != 0 || ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL gapped_counts: aborts=%0d ovs=%0d, want 0 and 1", ab_cnt - ab0, ov_cnt - ov0);
    end
  endtask

  task automatic test_restart();
    msg_t x, y;
    logic [319:0] sx, sy;
    int ab0, ov0;
    ab0 = ab_cnt; ov0 = ov_cnt;
    x = rand_msg(); y = rand_msg();
    sx = encode(x); sy = encode(y);
    for (int n = 0; n < 3; n++) drive(n == 0, 1'b1, beat_of(sx, n));
    drive(1'b1, 1'b1, beat_of(sy, 0));
    checks++;
    if ({abort_o, busy, out_valid} !== 3'b110) begin
      errors++;
      $display("FAIL restart_abort: abort=%b busy=%b ov=%b, want 1 1 0", abort_o, busy, out_valid);
    end
    for (int n = 1; n < 5; n++) drive(1'b0, 1'b1, beat_of(sy, n));
    last_exp = exp_rec(y);
    checks++;
    if (out_valid !== 1'b1 || obs_rec() !== last_exp) begin
      errors++;
      $display("FAIL restart_fields: ov=%b rec=%h, want ov=1 rec=%h", out_valid, obs_rec(), last_exp);
    end
    idle(2);
    checks++;
    if (ab_cnt - ab0 != 1 || ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL restart_counts: aborts=%0d ovs=%0d, want 1 and 1", ab_cnt - ab0, ov_cnt - ov0);
    end
  endtask

  task automatic test_timeout();
    msg_t x, y;
    logic [319:0] sx;
    x = rand_msg();
    sx = encode(x);
    drive(1'b1, 1'b1, beat_of(sx, 0));
    drive(1'b0, 1'b1, beat_of(sx, 1));
    idle(15);
    checks++;
    if ({busy, abort_o} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_15idle: busy=%b abort=%b, want busy=1 abort=0", busy, abort_o);
    end
    idle(1);
    checks++;
    if ({abort_o, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_abort: abort=%b busy=%b ov=%b, want 1 0 0", abort_o, busy, out_valid);
    end
    checks++;
    if (obs_rec() !== last_exp) begin
      errors++;
      $display("FAIL timeout_hold: rec=%h, want %h", obs_rec(), last_exp);
    end
    idle(1);
    checks++;
    if (abort_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: abort=%b, want 0", abort_o);
    end
    y = rand_msg();
    send(y, 1);
    last_exp = exp_rec(y);
    checks++;
    if (out_valid !== 1'b1 || obs_rec() !== last_exp) begin
      errors++;
      $display("FAIL timeout_next: ov=%b rec=%h, want ov=1 rec=%h", out_valid, obs_rec(), last_exp);
    end
  endtask

  task automatic test_errors();
    msg_t m;
    m = nominal_msg();
    m.len = 16'h0028;
    m.side = 8'h58;
    idle(1);
    send(m, 0);
    last_exp = exp_rec(m);
    checks++;
    if (out_valid !== 1'b1 || {buy_sell, length_err, side_err} !== 3'b011 || obs_rec() !== last_exp) begin
      errors++;
      $display("FAIL errors_flags: ov=%b bs=%b le=%b se=%b rec=%h, want ov=1 0 1 1 rec=%h",
               out_valid, buy_sell, length_err, side_err, obs_rec(), last_exp);
    end
    m = nominal_msg();
    m.side = 8'h53;
    idle(1);
    send(m, 0);
    last_exp = exp_rec(m);
    checks++;
    if ({out_valid, buy_sell, length_err, side_err} !== 4'b1000 || obs_rec() !== last_exp) begin
      errors++;
      $display("FAIL errors_sell: ov=%b bs=%b le=%b se=%b, want 1 0 0 0",
               out_valid, buy_sell, length_err, side_err);
    end
  endtask

  task automatic test_random();
    msg_t m;
    int junk;
    for (int i = 0; i < 20; i++) begin
      junk = $urandom_range(0, 3);
      // stray beats and starts without valid are ignored while idle
      for (int j = 0; j < junk; j++) drive(1'($urandom), 1'b0, 64'($urandom));
      if (junk > 1) drive(1'b0, 1'b1, {32'($urandom), 32'($urandom)});
      m = rand_msg();
      send(m, $urandom_range(0, 4));
      last_exp = exp_rec(m);
      checks++;
      if (out_valid !== 1'b1 || obs_rec() !== last_exp) begin
        errors++;
        $display("FAIL random_msg%0d: ov=%b rec=%h, want ov=1 rec=%h", i, out_valid, obs_rec(), last_exp);
      end
      idle(1);
    end
  endtask

  task automatic test_back_to_back();
    msg_t a, b, c;
    logic [319:0] sc;
    int t_a, ab0, ov0;
    a = rand_msg(); b = rand_msg(); c = rand_msg();
    send(a, 0);
    t_a = cyc;
    checks++;
    if (out_valid !== 1'b1 || obs_rec() !== exp_rec(a)) begin
      errors++;
      $display("FAIL b2b_first: ov=%b rec=%h, want ov=1 rec=%h", out_valid, obs_rec(), exp_rec(a));
    end
    send(b, 0);
    last_exp = exp_rec(b);
    checks++;
    if (out_valid !== 1'b1 || obs_rec() !== last_exp || cyc - t_a != 5) begin
      errors++;
      $display("FAIL b2b_second: ov=%b spacing=%0d rec=%h, want ov=1 spacing=5 rec=%h",
               out_valid, cyc - t_a, obs_rec(), last_exp);
    end
    sc = encode(c);
    for (int n = 0; n < 3; n++) drive(n == 0, 1'b1, beat_of(sc, n));
    ab0 = ab_cnt; ov0 = ov_cnt;
    rst = 1'b1;
    drive(1'b0, 1'b1, beat_of(sc, 3));
    rst = 1'b0;
    checks++;
    if ({obs_rec(), busy, out_valid, abort_o, dbg_state} !== '0) begin
      errors++;
      $display("FAIL midreset_zero: rec=%h busy=%b ov=%b abort=%b, want all zero",
               obs_rec(), busy, out_valid, abort_o);
    end
    drive(1'b0, 1'b1, beat_of(sc, 4));
    idle(3);
    checks++;
    if (ab_cnt - ab0 != 0 || ov_cnt - ov0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: aborts=%0d ovs=%0d busy=%b, want 0 0 0",
               ab_cnt - ab0, ov_cnt - ov0, busy);
    end
  endtask

  initial begin
    last_exp = '0;
    test_reset();
    test_nominal();
    test_gapped();
    test_restart();
    test_timeout();
    test_errors();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/itch_add_order_parser.md
Name: itch_add_order_parser

Overview:
- Downstream of the ITCH message-type decoder; consumes its add-order (no MPID) start pulse and the 64-bit message beat stream.
- Collects the five beats of an ITCH Add Order message, 38 bytes including the 2-byte length prefix.
- Extracts every field into registered outputs and pulses out_valid once per complete message.
- Detects restart, timeout, length and side errors.

Parameters:
- TIMEOUT, 16, idle cycles (no in_valid) tolerated in COLLECT before the message is aborted; range 1..255.
- EXP_LEN, 16'd36, expected value of the length prefix (message bytes excluding the prefix).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  add-order start; qualified by in_valid; marks in_data as beat 0 of a message
- in_valid  in  1  in_data carries a valid beat this cycle
- in_data  in  64  message beat; stream byte k of the beat on in_data[8k+7:8k]
- busy  out  1  high while in COLLECT
- out_valid  out  1  one-cycle pulse: field outputs updated with a complete message
- msg_length  out  16  length prefix
- stock_locate  out  16
- tracking_number  out  16
- timestamp  out  48
- order_ref  out  64
- buy_sell  out  1  1 = 'B' (8'h42), 0 otherwise
- shares  out  32
- stock  out  64  8 ASCII bytes; first byte in [63:56]
- price  out  32
- length_err  out  1  valid with out_valid: msg_length != EXP_LEN
- side_err  out  1  valid with out_valid: side byte is neither 8'h42 nor 8'h53
- abort  out  1  one-cycle pulse: partial message discarded

Behaviour:
- Reset: rst is synchronous, active-high, on clk. State IDLE, beat counter 0, timeout counter 0, capture buffer 0. All outputs 0.
- Message byte offsets (stream bytes 0..39 over beats 0..4; beat n holds bytes 8n..8n+7):
  - length 0-1
  - type 2
  - locate 3-4
  - tracking 5-6
  - timestamp 7-12
  - order_ref 13-20
  - side 21
  - shares 22-25
  - stock 26-33
  - price 34-37
  - bytes 38-39 are padding and ignored.
- Multi-byte fields are big-endian: the lowest stream offset is the MSB.
- The type byte is not checked; the upstream decoder already selected this parser.
- State IDLE:
  - start & in_valid: store beat 0, beat_cnt=1, tmo=0, go to COLLECT.
  - in_valid without start: ignored.
  - start without in_valid: ignored.
- State COLLECT, evaluated in priority order:
  1. start & in_valid: abort=1 next cycle; discard the partial message; store in_data as the new beat 0; beat_cnt=1; tmo=0; stay in COLLECT.
  2. in_valid: store beat[beat_cnt]; tmo=0.
     - If beat_cnt==4: go to IDLE and assert completion.
     - Else beat_cnt++.
  3. No in_valid: tmo++. When tmo reaches TIMEOUT: abort=1 next cycle, go to IDLE, no out_valid.
- Completion: on the cycle after beat 4 is accepted, out_valid=1 for exactly one cycle. All field outputs, length_err and side_err are updated in that same cycle.
- Field outputs hold until the next completion. Aborts and starts do not change them.
- Latency: the fastest message takes 5 consecutive in_valid beats; out_valid fires in cycle 6.
- Back-to-back: a start with beat 0 of the next message is accepted in the cycle immediately after beat 4. The out_valid of the previous message coincides with it.
- busy = (state == COLLECT), registered.
- Reset mid-message: discard everything, no out_valid, no abort pulse.

Test Plan:
- Nominal: 5 consecutive beats with length 0x0024, locate 0x0001, tracking 0x0000, ts 0x00000BEBC200, order_ref 0x0000000000000457, side 'B', shares 100 (0x00000064), stock "AAPL    ", price 0x001E8480 (200.0000) -> out_valid in cycle 6 with exactly those values; buy_sell=1; length_err=0, side_err=0.
- Gapped input: same message with 3 idle cycles between each beat (below TIMEOUT=16) -> identical fields; out_valid 1 cycle after the last beat; no abort.
- Restart: beats 0-2 of message X, then start with beat 0 of message Y, then Y beats 1-4 -> abort pulse 1 cycle after Y's start; single out_valid with Y's fields only.
- Timeout: beats 0-1 then 16 idle cycles -> abort pulse; busy falls; no out_valid. A following full message decodes normally.
- Errors: length 0x0028 and side byte 0x58 -> out_valid with length_err=1, side_err=1, buy_sell=0. Fields are still decoded.
- Back-to-back plus reset: two messages with no gap -> two out_valid pulses 5 cycles apart. rst asserted at beat 3 of a third message -> all outputs 0; no out_valid, no abort.
